// File: rtl/shift_result_collector.sv
// shift_result_collector
// Tracks shift operations through the fixed-latency barrel shifter, captures
// the shifter output on the cycle it is valid, and buffers {data, tag} pairs
// in a small first-word-fall-through FIFO drained by a ready/valid consumer.
// Issue is credit-limited (inflight + count < DEPTH), so the FIFO cannot overflow.
module shift_result_collector #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 6,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [TAG_W-1:0]             issue_tag,
  input  logic [WIDTH-1:0]             shifter_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH-1:0]             res_data,
  output logic [TAG_W-1:0]             res_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   inflight
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so inflight + count can never wrap before the compare.
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_FULL = CW'(DEPTH);

  logic fire;
  logic pop;
  logic cap;
  logic [TAG_W-1:0] cap_tag;

  // Delay line mirroring the shifter pipeline: one {valid, tag} per stage.
  logic             dl_valid_reg [LATENCY];
  logic [TAG_W-1:0] dl_tag_reg   [LATENCY];

  // FIFO storage and bookkeeping.
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [CW-1:0]    inflight_reg, inflight_next;

  // Credit check uses registered counters only, so it ignores a same-cycle pop.
  always_comb begin
    issue_ready = !rst && (({1'b0, inflight_reg} + {1'b0, count_reg}) < DEPTH_LIM);
  end

  assign fire     = issue_valid & issue_ready;
  assign cap      = dl_valid_reg[LATENCY-1];
  assign cap_tag  = dl_tag_reg[LATENCY-1];
  assign res_valid = (count_reg != '0);
  assign pop      = res_valid & res_ready;

  // Fall-through head: read storage directly at the read pointer.
  assign res_data = mem_data[rd_ptr_reg];
  assign res_tag  = mem_tag[rd_ptr_reg];
  assign count    = count_reg;
  assign inflight = inflight_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage samples the accepted request alongside the shifter input.
        always_ff @(posedge clk) begin
          if (rst) begin
            dl_valid_reg[0] <= 1'b0;
            dl_tag_reg[0]   <= '0;
          end else begin
            dl_valid_reg[0] <= fire;
            dl_tag_reg[0]   <= issue_tag;
          end
        end
      end else begin : g_rest
        // Later stages shift unconditionally; the shifter never stalls.
        always_ff @(posedge clk) begin
          if (rst) begin
            dl_valid_reg[gi] <= 1'b0;
            dl_tag_reg[gi]   <= '0;
          end else begin
            dl_valid_reg[gi] <= dl_valid_reg[gi-1];
            dl_tag_reg[gi]   <= dl_tag_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Write the captured result into storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && cap) begin
      mem_data[wr_ptr_reg] <= shifter_out;
      mem_tag[wr_ptr_reg]  <= cap_tag;
    end
  end

  // Next-state for pointers and occupancy counters.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg + PW'(cap);
    rd_ptr_next   = rd_ptr_reg + PW'(pop);
    inflight_next = inflight_reg + CW'(fire) - CW'(cap);
    count_next    = count_reg + CW'(cap) - CW'(pop);
  end

  // Pointer and counter registers; reset flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
    end
  end

  // A capture into a full FIFO means the credit logic was bypassed.
  always_ff @(posedge clk) begin
    if (!rst && cap) begin
      assert (count_reg != DEPTH_FULL)
        else $error("shift_result_collector: capture while FIFO full");
    end
  end

endmodule

// File: tb/tb_shift_result_collector.sv
// Directed bench for shift_result_collector with a 6-stage shifter model
// and a queue scoreboard of expected {tag, data} results.
module tb_shift_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_tag;
  logic [31:0] shifter_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic [3:0]  count;
  logic [3:0]  inflight;

  int total = 0;
  int bad   = 0;
  int fires = 0;
  logic last_fire;

  logic [35:0] sb [$];
  logic [31:0] pipe [6];
  logic [31:0] pipe_in;

  always #5 clk = ~clk;

  shift_result_collector #(.WIDTH(32), .LATENCY(6), .DEPTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .shifter_out(shifter_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .count(count), .inflight(inflight)
  );

  // Shifter model: six register stages, no reset, never stalls.
  always @(posedge clk) begin
    pipe[0] <= pipe_in;
    for (int s = 1; s < 6; s++) pipe[s] <= pipe[s-1];
  end
  assign shifter_out = pipe[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
      end
  endtask

  // One cycle: drive at the falling edge, then score pop/fire before the rising edge.
  task automatic step(input logic r, input logic iv, input logic [3:0] tg,
                      input logic rr, input logic [31:0] d);
    logic [35:0] e;
    @(negedge clk);
    rst = r; issue_valid = iv; issue_tag = tg; res_ready = rr;
    #1;
    if (res_valid && res_ready) begin
      total++;
      assert (sb.size() != 0)
        else begin
          bad++;
          $error("FAIL unexpected_result observed=tag%0h/%0h expected=none", res_tag, res_data);
        end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_data", res_data, e[31:0]);
        chk("res_tag", {28'd0, res_tag}, {28'd0, e[35:32]});
        $display("pop  tag=%0h data=%08h", res_tag, res_data);
      end
    end
    last_fire = issue_valid && issue_ready;
    if (last_fire) begin
      sb.push_back({tg, d});
      fires++;
      pipe_in = d;
      $display("fire tag=%0h data=%08h", tg, d);
    end else begin
      pipe_in = $urandom;
    end
  endtask

  initial begin
    int f0;
    int n;
    logic [31:0] op;
    rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; res_ready = 1'b0; pipe_in = '0;
    for (int s = 0; s < 6; s++) pipe[s] = '0;

    // Reset state
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 4'h0, 0, 32'h0);
      chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_count", {28'd0, count}, 32'd0);
      chk("rst_inflight", {28'd0, inflight}, 32'd0);
    end

    // Single op: fire in cycle 3, result visible 7 cycles later
    step(0, 1, 4'h5, 0, 32'h1 << 31);
    chk("single_fire", {31'd0, last_fire}, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 4'h0, 0, 32'h0);
      chk("single_latency_valid", {31'd0, res_valid}, 32'd0);
      chk("single_inflight", {28'd0, inflight}, 32'd1);
    end
    step(0, 0, 4'h0, 1, 32'h0);
    chk("single_valid", {31'd0, res_valid}, 32'd1);
    chk("single_count", {28'd0, count}, 32'd1);
    chk("single_inflight_done", {28'd0, inflight}, 32'd0);
    step(0, 0, 4'h0, 0, 32'h0);
    chk("single_empty", {28'd0, count}, 32'd0);

    // Credit backpressure: only 8 accepted while consumer stalls
    f0 = fires;
    for (int k = 0; k < 12; k++) begin
      op = $urandom;
      step(0, 1, k[3:0], 0, op << (k % 32));
      if (k == 8) chk("credit_ready_low", {31'd0, issue_ready}, 32'd0);
    end
    chk("credit_fires", fires - f0, 32'd8);
    for (int k = 0; k < 7; k++) step(0, 0, 4'h0, 0, 32'h0);
    chk("credit_count_full", {28'd0, count}, 32'd8);
    chk("credit_inflight", {28'd0, inflight}, 32'd0);
    chk("credit_ready_full", {31'd0, issue_ready}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 4'h0, 1, 32'h0);
      if (k == 0) chk("credit_ready_before_pop", {31'd0, issue_ready}, 32'd0);
      if (k == 1) chk("credit_ready_after_pop", {31'd0, issue_ready}, 32'd1);
    end
    chk("credit_drained", sb.size(), 32'd0);

    // Streaming: cap and pop every cycle, count holds at 1
    f0 = fires;
    for (int k = 0; k < 40; k++) begin
      op = $urandom;
      step(0, 1, k[3:0], 1, op >> (k % 32));
      if (k >= 7) begin
        chk("stream_valid", {31'd0, res_valid}, 32'd1);
        chk("stream_count", {28'd0, count}, 32'd1);
      end
    end
    for (int k = 0; k < 10; k++) step(0, 0, 4'h0, 1, 32'h0);
    chk("stream_fires", fires - f0, 32'd40);
    chk("stream_drained", sb.size(), 32'd0);

    // Wrap-around with a random consumer
    n = 0;
    for (int cyc = 0; cyc < 400 && (n < 20 || sb.size() != 0); cyc++) begin
      op = $urandom;
      step(0, n < 20, n[3:0], 1'($urandom_range(0, 1)), op << $urandom_range(0, 31));
      if (last_fire) n++;
    end
    chk("wrap_ops", n, 32'd20);
    chk("wrap_drained", sb.size(), 32'd0);

    // Reset mid-flight: three ops dropped, late shifter data ignored
    for (int k = 0; k < 3; k++) step(0, 1, k[3:0], 0, 32'hA000_0000 + k);
    step(1, 0, 4'h0, 0, 32'h0);
    sb.delete();
    step(0, 0, 4'h0, 0, 32'h0);
    chk("rstmid_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rstmid_count", {28'd0, count}, 32'd0);
    chk("rstmid_inflight", {28'd0, inflight}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 4'h0, 0, 32'h0);
      chk("rstmid_res_valid", {31'd0, res_valid}, 32'd0);
    end

    // Idle: shifter output toggles, nothing is captured
    for (int k = 0; k < 50; k++) begin
      step(0, 0, 4'h0, 1, 32'h0);
      chk("idle_res_valid", {31'd0, res_valid}, 32'd0);
    end
    chk("idle_count", {28'd0, count}, 32'd0);
    chk("idle_inflight", {28'd0, inflight}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_result_collector.md
Name: shift_result_collector

Overview:
- Downstream companion to the 6-stage pipelined 32-bit barrel shifter.
- The shifter's data path has no valid tracking, so this block does it. It tracks each accepted shift request through the shifter's fixed latency, captures the shifter output on the exact cycle it is valid, and buffers results in a FIFO.
- Results are presented to the consumer with a ready/valid handshake. Upstream issue is credit-limited so the FIFO can never overflow.

Parameters:
- WIDTH, 32, data width of shifter output and res_data.
- LATENCY, 6, number of register stages between shifter input and shifter out.
- DEPTH, 8, FIFO entries; also the maximum of inflight + count. Power of two, at least 2.
- TAG_W, 4, width of the user tag carried alongside each request.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  requester presents a shift operation to the shifter this cycle.
- issue_ready  output  1  collector has credit; an operation is accepted when issue_valid & issue_ready.
- issue_tag  input  TAG_W  tag travelling with the operation.
- shifter_out  input  WIDTH  shifter output bus.
- res_valid  output  1  FIFO head is valid.
- res_ready  input  1  consumer accepts the head.
- res_data  output  WIDTH  head result.
- res_tag  output  TAG_W  head tag.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.
- inflight  output  $clog2(DEPTH+1)  operations accepted but not yet captured.

Behaviour:
- Reset:
  - res_valid=0, count=0, inflight=0.
  - FIFO pointers = 0.
  - Valid/tag delay line fully cleared.
  - res_data and res_tag are don't-care while res_valid=0.
  - issue_ready=0 while rst is high.
- fire = issue_valid & issue_ready.
- issue_ready = !rst & (inflight + count < DEPTH). Combinational from registered counters only; it does not depend on res_ready in the same cycle, which makes it conservative.
- Delay line:
  - LATENCY register stages, each carrying {valid, tag}.
  - Stage 1 loads {fire, issue_tag}.
  - Stages shift every cycle with no stall; the shifter cannot stall.
- Capture timing: an op fired in cycle T has its shifter_out valid during cycle T+LATENCY. The last delay stage is valid in that same cycle (cap).
- cap: write {shifter_out, tag} into FIFO at wr_ptr on the edge ending T+LATENCY. wr_ptr increments modulo DEPTH.
- FIFO head:
  - res_valid=1 from cycle T+LATENCY+1 for an empty FIFO.
  - Total issue-to-res_valid latency is LATENCY+1 = 7 cycles.
- pop = res_valid & res_ready: rd_ptr increments modulo DEPTH. res_data/res_tag reflect the new head in the next cycle.
- Output path: first-word-fall-through. res_data/res_tag are read directly from storage at rd_ptr; no extra bubble.
- Counter updates:
  - inflight_next = inflight + fire - cap.
  - count_next = count + cap - pop.
  - fire and cap in the same cycle leave inflight unchanged.
  - cap and pop in the same cycle leave count unchanged. This includes count=1, where res_valid stays 1 and the next entry is presented.
- Full: count=DEPTH only when inflight=0. cap never coincides with a full FIFO because of credit. A cap while full is a design error; flag it with an assertion in simulation.
- Empty: res_valid=0. A pop while empty is impossible, since res_ready is ignored when res_valid=0.
- Pointer wrap: pointers carry no extra bit; occupancy comes from count.
- Reset mid-operation:
  - All in-flight operations are dropped and the FIFO is flushed.
  - Shifter outputs emerging after reset release are ignored, because the delay line was cleared.
  - issue_ready returns to 1 in the first cycle after rst deasserts.

Test Plan:
- Single op: rst 2 cycles, then issue_valid=1 for one cycle in cycle 3 with tag=0x5; model shifter returns 0x80000000 in cycle 9 -> res_valid=1 in cycle 10, res_data=0x80000000, res_tag=0x5, inflight 1->0 at cycle 10, count=1.
- Credit backpressure: res_ready=0, issue_valid held high -> exactly 8 fires. issue_ready=0 from the cycle after the 8th fire; count reaches 8, inflight reaches 0. Then res_ready=1 -> 8 results in tag order 0..7, with issue_ready reasserting the cycle after the first pop.
- Simultaneous cap/pop: steady stream, issue_valid=1 and res_ready=1 every cycle -> after the 7-cycle fill, res_valid stays 1 and one result is delivered per cycle, count constant at 1, no lost or duplicated tags across 40 ops.
- Wrap-around: 20 ops with res_ready toggling in a pseudo-random pattern -> all 20 delivered in order, data matching shift model, pointers wrap past DEPTH twice, no overflow assertion.
- Reset mid-flight: fire 3 ops, assert rst for 1 cycle at cycle T+3 -> after release count=0, inflight=0, res_valid=0 forever; no result appears even though the shifter still emits data at T+6..T+8.
- Idle: issue_valid=0 for 50 cycles while shifter_out toggles -> res_valid stays 0, count=0.
